gray_to_heatmap: RTL and testbench

Streaming pseudo-colour mapper for the video pipeline. Takes 8-bit grey samples, such as a grey channel produced by the grayscale stage, and expands each one back to a 24-bit {R,G,B} pixel, either as a grey replica or as a four-segment heat-map palette. It is a two-stage registered pipeline with valid/ready handshakes on both sides. Position counters tag every output pixel with start-of-frame and end-of-line flags for the downstream VGA/framebuffer writer.

---
 rtl/gray_to_heatmap.sv | 124 ++++++++++++
 tb/tb_gray_to_heatmap.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_to_heatmap.sv
// Streaming grey -> {R,G,B} mapper: grey replica or four-segment heat-map palette.
// Two registered stages with valid/ready on both sides; stage 2 carries frame position flags.
module gray_to_heatmap #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic [7:0]  gray_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] pix_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eol
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    // stage 1: raw sample and its mode
    logic          v1_q, v1_d;
    logic [7:0]    g1_q, g1_d;
    logic          m1_q, m1_d;
    // stage 2: mapped pixel and its position in the frame
    logic          v2_q, v2_d;
    logic [23:0]   pix_q, pix_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    logic          ld1, ld2, out_fire;
    logic [1:0]    seg;
    logic [7:0]    frac, frac_n;
    logic [23:0]   map_rgb;

    assign out_fire = v2_q && out_ready;
    assign ld2      = v1_q && (!v2_q || out_ready);
    assign in_ready = !v1_q || !v2_q || out_ready;
    assign ld1      = in_valid && in_ready;

    // Palette: blue -> cyan -> green -> yellow -> red, each segment a 64-step ramp.
    always_comb begin
        seg     = g1_q[7:6];
        frac    = {g1_q[5:0], 2'b00};
        frac_n  = 8'd255 - frac;
        map_rgb = {g1_q, g1_q, g1_q};
        if (m1_q) begin
            case (seg)
                2'd0:    map_rgb = {8'd0,   frac,   8'd255};
                2'd1:    map_rgb = {8'd0,   8'd255, frac_n};
                2'd2:    map_rgb = {frac,   8'd255, 8'd0};
                default: map_rgb = {8'd255, frac_n, 8'd0};
            endcase
        end
    end

    always_comb begin
        v1_d = v1_q;
        g1_d = g1_q;
        m1_d = m1_q;
        if (ld1) begin
            v1_d = 1'b1;
            g1_d = gray_in;
            m1_d = mode;
        end else if (ld2) begin
            v1_d = 1'b0;
        end
    end

    always_comb begin
        v2_d  = v2_q;
        pix_d = pix_q;
        if (ld2) begin
            v2_d  = 1'b1;
            pix_d = map_rgb;
        end else if (out_fire) begin
            v2_d  = 1'b0;
        end
    end

    // Position follows the stage-2 pixel, so it only moves when that pixel leaves.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (out_fire) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q  <= 1'b0;
            g1_q  <= '0;
            m1_q  <= 1'b0;
            v2_q  <= 1'b0;
            pix_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            v1_q  <= v1_d;
            g1_q  <= g1_d;
            m1_q  <= m1_d;
            v2_q  <= v2_d;
            pix_q <= pix_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign out_valid = v2_q;
    assign pix_out   = pix_q;
    assign out_sof   = v2_q && (x_q == '0) && (y_q == '0);
    assign out_eol   = v2_q && (x_q == X_LAST);

endmodule

// File: tb/tb_gray_to_heatmap.sv
// Directed + random bench for gray_to_heatmap with a small frame (4x2) to exercise framing.
module tb_gray_to_heatmap;
    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic [7:0]  gray_in = 8'h00;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_sof, out_eol;
    logic [23:0] pix_out;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int opos = 0;
    bit lat_on = 0;
    bit rnd_rdy = 0;
    logic [23:0] expq[$];
    int          accq[$];
    bit          stall_q = 0;
    logic [25:0] stall_v = '0;

    always #5 clk = ~clk;

    gray_to_heatmap #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .reset(reset), .mode(mode), .gray_in(gray_in),
        .in_valid(in_valid), .in_ready(in_ready), .pix_out(pix_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] hm(input logic [7:0] g, input logic m);
        logic [7:0] f;
        f = {g[5:0], 2'b00};
        if (!m) return {g, g, g};
        case (g[7:6])
            2'd0:    return {8'h00, f, 8'hFF};
            2'd1:    return {8'h00, 8'hFF, 8'hFF - f};
            2'd2:    return {f, 8'hFF, 8'h00};
            default: return {8'hFF, 8'hFF - f, 8'h00};
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom % 2);
    end

    // Output monitor: scoreboard pop, framing flags from output count, stall stability.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            stall_q = 0;
        end else begin
            if (stall_q && out_valid)
                chk("stall_hold", 32'({pix_out, out_sof, out_eol}), 32'(stall_v));
            stall_q = out_valid && !out_ready;
            stall_v = {pix_out, out_sof, out_eol};
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("extra_out", 32'd1, 32'd0);
                end else begin
                    logic [23:0] e;
                    int a;
                    e = expq.pop_front();
                    a = accq.pop_front();
                    chk("pix", 32'(pix_out), 32'(e));
                    chk("sof", 32'(out_sof), 32'(opos % (H*V) == 0));
                    chk("eol", 32'(out_eol), 32'(opos % H == H-1));
                    if (lat_on) chk("latency", 32'(cyc - a), 32'd2);
                    opos++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] g, input logic m, input logic [23:0] e);
        int n = 0;
        gray_in = g; mode = m; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 200) begin chk("in_timeout", 32'd0, 32'd1); break; end
            @(negedge clk);
        end
        expq.push_back(e);
        accq.push_back(cyc);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("drain", 32'(expq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [7:0]  m1g[6] = '{8'h00, 8'h40, 8'h7F, 8'h80, 8'hC0, 8'hFF};
    logic [23:0] m1e[6] = '{24'h0000FF, 24'h00FFFF, 24'h00FF03, 24'h00FF00, 24'hFFFF00, 24'hFF0300};
    logic [7:0]  bpg[6] = '{8'h10, 8'h50, 8'h90, 8'hD0, 8'h3F, 8'hC1};
    logic [23:0] bpe[6] = '{24'h0040FF, 24'h00FFBF, 24'h40FF00, 24'hFFBF00, 24'h00FCFF, 24'hFFFB00};

    initial begin
        int k;
        logic [7:0] g;
        logic m;
        // reset state while held
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pix", 32'(pix_out), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", 32'({out_sof, out_eol}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // heat-map stream, back-to-back, latency checked
        out_ready = 1'b1;
        lat_on = 1;
        for (int i = 0; i < 6; i++) send(m1g[i], 1'b1, m1e[i]);
        drain();
        lat_on = 0;

        // grey replica and per-pixel mode switch
        send(8'h00, 1'b0, 24'h000000);
        send(8'h5A, 1'b0, 24'h5A5A5A);
        send(8'hFF, 1'b0, 24'hFFFFFF);
        send(8'h80, 1'b0, 24'h808080);
        send(8'h80, 1'b1, 24'h00FF00);
        drain();

        // backpressure: out_ready low for 5 cycles, continuous input
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            gray_in = bpg[k]; mode = 1'b1; in_valid = 1'b1;
            @(negedge clk);
            chk(i < 2 ? "bp_ready_hi" : "bp_ready_lo", 32'(in_ready), i < 2 ? 32'd1 : 32'd0);
            if (in_ready) begin
                expq.push_back(bpe[k]); accq.push_back(cyc); k++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1 chk("bp_release", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        for (int i = k; i < 6; i++) send(bpg[i], 1'b1, bpe[i]);
        drain();
        chk("count_pre_rst", 32'(opos), 32'd17);

        // reset with both stages full
        out_ready = 1'b0;
        send(8'h11, 1'b0, 24'h111111);
        send(8'h22, 1'b0, 24'h222222);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_pix", 32'(pix_out), 32'h0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        expq.delete();
        accq.delete();
        opos = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;

        // framing: 10 pixels over a 4x2 frame, first after reset carries sof
        for (int i = 0; i < 10; i++) begin
            g = 8'(i * 29 + 3);
            m = 1'(i % 2);
            send(g, m, hm(g, m));
        end
        drain();
        chk("frame_count", 32'(opos), 32'd10);

        // random handshakes on both sides
        rnd_rdy = 1;
        for (int i = 0; i < 1000; i++) begin
            while ($urandom % 2) begin @(posedge clk); #1; end
            g = 8'($urandom);
            m = 1'($urandom % 2);
            send(g, m, hm(g, m));
        end
        drain();
        rnd_rdy = 0;
        chk("total_out", 32'(opos), 32'd1010);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
